nn_layer_sequencer: RTL and testbench

Central sequencer for the fully-connected inference datapath. It replaces the hard-wired start/done daisy chain between weight loaders, bias loaders and FC layer engines. After the top-level controller has filled the input buffer and pulses `run`, the block walks NUM_STAGES stages in order. Each stage runs three phases: weight load, then bias load, then compute. After each compute phase it emits a capture strobe so the controller can latch the layer result, and it signals overall completion back to the controller FSM.

---
 rtl/nn_layer_sequencer.sv | 175 +++++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: steps NUM_STAGES layer stages through weight-load, bias-load and
// compute phases with capture/done strobes. Define SEQ_TIMEOUT_EN for the per-phase timeout.
module nn_layer_sequencer #(
    parameter int NUM_STAGES     = 3,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int SW             = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk_100MHz,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  abort,
    output logic [NUM_STAGES-1:0] wload_start,
    input  logic [NUM_STAGES-1:0] wload_done,
    output logic [NUM_STAGES-1:0] bload_start,
    input  logic [NUM_STAGES-1:0] bload_done,
    output logic [NUM_STAGES-1:0] fc_start,
    input  logic [NUM_STAGES-1:0] fc_done,
    output logic [SW-1:0]         stage_idx,
    output logic                  capture,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LOAD_W  = 4'd1;
    localparam logic [3:0] S_WAIT_W  = 4'd2;
    localparam logic [3:0] S_LOAD_B  = 4'd3;
    localparam logic [3:0] S_WAIT_B  = 4'd4;
    localparam logic [3:0] S_COMPUTE = 4'd5;
    localparam logic [3:0] S_WAIT_C  = 4'd6;
    localparam logic [3:0] S_CAPTURE = 4'd7;
    localparam logic [3:0] S_FINISH  = 4'd8;

    if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_num_stages
        $error("nn_layer_sequencer: NUM_STAGES must be 1..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("nn_layer_sequencer: TIMEOUT_CYCLES must be 1..65535");
    end

    logic [3:0]    state;
    logic [3:0]    state_nxt;
    logic [SW-1:0] stage_cnt;
    logic [SW-1:0] stage_nxt;
    logic          cur_done;
    logic          last_stage;
    logic          timeout;

    assign last_stage = (stage_cnt == SW'(NUM_STAGES - 1));

    // Only the current stage's done bit, and only in the matching WAIT state, is observed.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        cur_done = 1'b0;
        case (state)
            S_WAIT_W: cur_done = wload_done[stage_cnt];
            S_WAIT_B: cur_done = bload_done[stage_cnt];
            S_WAIT_C: cur_done = fc_done[stage_cnt];
            default:  cur_done = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        stage_nxt = stage_cnt;
        if (abort || timeout) begin
            state_nxt = S_IDLE;
            stage_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state_nxt = S_LOAD_W;
                        stage_nxt = '0;
                    end
                end
                S_LOAD_W:  state_nxt = S_WAIT_W;
                S_WAIT_W:  if (cur_done) state_nxt = S_LOAD_B;
                S_LOAD_B:  state_nxt = S_WAIT_B;
                S_WAIT_B:  if (cur_done) state_nxt = S_COMPUTE;
                S_COMPUTE: state_nxt = S_WAIT_C;
                S_WAIT_C:  if (cur_done) state_nxt = S_CAPTURE;
                S_CAPTURE: begin
                    if (last_stage) begin
                        state_nxt = S_FINISH;
                    end else begin
                        state_nxt = S_LOAD_W;
                        stage_nxt = stage_cnt + SW'(1);
                    end
                end
                S_FINISH: begin
                    state_nxt = S_IDLE;
                    stage_nxt = '0;
                end
                default: begin
                    state_nxt = S_IDLE;
                    stage_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            stage_cnt <= '0;
        end else begin
            // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
            state     <= state_nxt;
            stage_cnt <= stage_nxt;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt;
    logic        in_wait;

    assign in_wait = (state == S_WAIT_W) || (state == S_WAIT_B) || (state == S_WAIT_C);
    assign timeout = in_wait && !cur_done && (wait_cnt == TO_LAST);

    // Every WAIT state is entered from a LOAD/COMPUTE state, so the count restarts at 0.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!in_wait) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            error <= 1'b0;
        end else if (abort) begin
            error <= error;
        end else if (state == S_IDLE && run) begin
            error <= 1'b0;
        end else if (timeout) begin
            error <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

    // Moore output decode.
    always_comb begin
        wload_start = '0;
        bload_start = '0;
        fc_start    = '0;
        case (state)
            S_LOAD_W:  wload_start[stage_cnt] = 1'b1;
            S_LOAD_B:  bload_start[stage_cnt] = 1'b1;
            S_COMPUTE: fc_start[stage_cnt]    = 1'b1;
            default:   ;
        endcase
    end

    assign stage_idx = stage_cnt;
    assign capture   = (state == S_CAPTURE);
    assign done      = (state == S_FINISH);
    assign busy      = (state != S_IDLE);

    a_start_onehot: assert property (@(posedge clk_100MHz) disable iff (!rst_n)
        $onehot0({wload_start, bload_start, fc_start}));

    a_stage_range: assert property (@(posedge clk_100MHz) disable iff (!rst_n)
        stage_cnt <= SW'(NUM_STAGES - 1));

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: handshake responders, strobe monitor and a
// small timing model of the stage walk. Timeout cases run when SEQ_TIMEOUT_EN is defined.
module tb_nn_layer_sequencer;

    localparam int NS    = 3;
    localparam int NEVER = 1000000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic          abort;
    logic [NS-1:0] wload_start, bload_start, fc_start;
    logic [NS-1:0] wload_done, bload_done, fc_done;
    logic [NS-1:0] w_resp = '0, b_resp = '0, c_resp = '0;
    logic [NS-1:0] w_spur = '0, b_spur = '0, c_spur = '0;
    logic [1:0]    stage_idx;
    logic          capture, busy, done, error;

    assign wload_done = w_resp | w_spur;
    assign bload_done = b_resp | b_spur;
    assign fc_done    = c_resp | c_spur;

    int w_dly[NS], b_dly[NS], c_dly[NS];
    int w_pend[NS], b_pend[NS], c_pend[NS];
    int edge_n   = 0;
    int run_edge = 0;
    int st_code[$], st_rel[$], cap_stage[$], cap_rel[$];
    int done_cnt    = 0;
    int done_rel    = 0;
    int multi_start = 0;
    int n_checks    = 0;
    int n_fail      = 0;

    nn_layer_sequencer #(
        .NUM_STAGES    (NS),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_100MHz (clk),
        .rst_n      (rst_n),
        .run        (run),
        .abort      (abort),
        .wload_start(wload_start),
        .wload_done (wload_done),
        .bload_start(bload_start),
        .bload_done (bload_done),
        .fc_start   (fc_start),
        .fc_done    (fc_done),
        .stage_idx  (stage_idx),
        .capture    (capture),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n = edge_n + 1;

    // Responders: a start seen in cycle n yields a one-cycle done in cycle n+1+delay.
    always @(negedge clk) begin
        w_resp = '0;
        b_resp = '0;
        c_resp = '0;
        for (int s = 0; s < NS; s++) begin
            if (w_pend[s] > 0) begin w_pend[s]--; if (w_pend[s] == 0) w_resp[s] = 1'b1; end
            if (b_pend[s] > 0) begin b_pend[s]--; if (b_pend[s] == 0) b_resp[s] = 1'b1; end
            if (c_pend[s] > 0) begin c_pend[s]--; if (c_pend[s] == 0) c_resp[s] = 1'b1; end
            if (wload_start[s]) w_pend[s] = 1 + w_dly[s];
            if (bload_start[s]) b_pend[s] = 1 + b_dly[s];
            if (fc_start[s])    c_pend[s] = 1 + c_dly[s];
        end
    end

    // Monitor: log strobes with their cycle number relative to the accepting edge.
    always @(negedge clk) begin
        int rel;
        rel = edge_n - run_edge;
        for (int s = 0; s < NS; s++) begin
            if (wload_start[s]) begin st_code.push_back(s);      st_rel.push_back(rel); end
            if (bload_start[s]) begin st_code.push_back(8 + s);  st_rel.push_back(rel); end
            if (fc_start[s])    begin st_code.push_back(16 + s); st_rel.push_back(rel); end
        end
        if ($countones({wload_start, bload_start, fc_start}) > 1) multi_start++;
        if (capture) begin cap_stage.push_back(int'(stage_idx)); cap_rel.push_back(rel); end
        if (done) begin done_cnt++; done_rel = rel; end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    // Leaves the bench at the falling edge of cycle 1 (state LOAD_W if accepted).
    task automatic start_run();
        @(negedge clk);
        run      = 1'b1;
        run_edge = edge_n;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, input string tag);
        int n;
        n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, " done_seen"}, done_cnt - base, 1);
    endtask

    // Timing model: each phase costs 2 cycles plus its extra wait, capture costs 1.
    task automatic check_seq(input string tag, input int sb, input int cb);
        int t;
        int k;
        t = 1;
        k = sb;
        for (int s = 0; s < NS; s++) begin
            check($sformatf("%s W%0d code", tag, s), qget(st_code, k), s);
            check($sformatf("%s W%0d cyc", tag, s), qget(st_rel, k), t);
            k++; t += 2 + w_dly[s];
            check($sformatf("%s B%0d code", tag, s), qget(st_code, k), 8 + s);
            check($sformatf("%s B%0d cyc", tag, s), qget(st_rel, k), t);
            k++; t += 2 + b_dly[s];
            check($sformatf("%s C%0d code", tag, s), qget(st_code, k), 16 + s);
            check($sformatf("%s C%0d cyc", tag, s), qget(st_rel, k), t);
            k++; t += 2 + c_dly[s];
            check($sformatf("%s cap%0d stage", tag, s), qget(cap_stage, cb + s), s);
            check($sformatf("%s cap%0d cyc", tag, s), qget(cap_rel, cb + s), t);
            t += 1;
        end
        check({tag, " n_starts"}, st_code.size() - sb, 3 * NS);
        check({tag, " n_captures"}, cap_stage.size() - cb, NS);
        check({tag, " done_model"}, done_rel, t);
    endtask

    task automatic clear_delays();
        for (int s = 0; s < NS; s++) begin
            w_dly[s] = 0;
            b_dly[s] = 0;
            c_dly[s] = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sb, cb, db;
        run   = 1'b0;
        abort = 1'b0;
        rst_n = 1'b0;
        clear_delays();

        repeat (2) @(negedge clk);
        check("rst wload_start", wload_start, 0);
        check("rst bload_start", bload_start, 0);
        check("rst fc_start", fc_start, 0);
        check("rst capture", capture, 0);
        check("rst done", done, 0);
        check("rst busy", busy, 0);
        check("rst error", error, 0);
        check("rst stage_idx", stage_idx, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal sequence.
        sb = st_code.size(); cb = cap_stage.size(); db = done_cnt;
        start_run();
        check("nom busy_rise", busy, 1);
        wait_done(db, 100, "nom");
        check("nom done_cycle", done_rel, 22);
        check_seq("nom", sb, cb);
        @(negedge clk);
        check("nom busy_fall", busy, 0);
        check("nom stage_reset", stage_idx, 0);
        check("nom single_done", done_cnt - db, 1);

        // Slow bias loader on stage 1.
        b_dly[1] = 40;
        sb = st_code.size(); cb = cap_stage.size(); db = done_cnt;
        start_run();
        wait_done(db, 200, "slow");
        check("slow done_cycle", done_rel, 62);
        check_seq("slow", sb, cb);
        clear_delays();
        repeat (3) @(negedge clk);

        // Spurious done bits of other stages while stage 0 waits for its weights.
        w_dly[0] = 5;
        sb = st_code.size(); cb = cap_stage.size(); db = done_cnt;
        start_run();
        repeat (2) @(negedge clk);
        w_spur[1] = 1'b1;
        c_spur[2] = 1'b1;
        check("spur stage_idx", stage_idx, 0);
        @(negedge clk);
        w_spur = '0;
        c_spur = '0;
        check("spur still_waiting", st_code.size() - sb, 1);
        wait_done(db, 100, "spur");
        check("spur done_cycle", done_rel, 27);
        check_seq("spur", sb, cb);
        clear_delays();
        repeat (3) @(negedge clk);

        // Abort in WAIT_C of stage 1.
        c_dly[1] = 10;
        sb = st_code.size(); cb = cap_stage.size(); db = done_cnt;
        start_run();
        repeat (13) @(negedge clk);
        check("abort in_wait_c", stage_idx, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", busy, 0);
        check("abort stage_idx", stage_idx, 0);
        repeat (20) @(negedge clk);
        check("abort n_starts", st_code.size() - sb, 6);
        check("abort n_captures", cap_stage.size() - cb, 1);
        check("abort no_done", done_cnt - db, 0);
        check("abort busy_after", busy, 0);
        clear_delays();
        sb = st_code.size(); cb = cap_stage.size(); db = done_cnt;
        start_run();
        wait_done(db, 100, "restart");
        check("restart done_cycle", done_rel, 22);
        check_seq("restart", sb, cb);
        repeat (3) @(negedge clk);

        // run while busy is ignored.
        sb = st_code.size(); cb = cap_stage.size(); db = done_cnt;
        start_run();
        repeat (9) @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        wait_done(db, 100, "busyrun");
        check("busyrun done_cycle", done_rel, 22);
        check_seq("busyrun", sb, cb);
        repeat (3) @(negedge clk);

        // abort wins over run in IDLE.
        sb = st_code.size(); db = done_cnt;
        run   = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        run   = 1'b0;
        abort = 1'b0;
        check("abortrun busy", busy, 0);
        repeat (3) @(negedge clk);
        check("abortrun no_starts", st_code.size() - sb, 0);
        check("abortrun busy_later", busy, 0);

        // Asynchronous reset truncates the bias-load strobe of stage 0.
        start_run();
        repeat (2) @(negedge clk);
        check("midrst bload_pre", bload_start, 3'b001);
        #1 rst_n = 1'b0;
        #1;
        check("midrst bload", bload_start, 0);
        check("midrst busy", busy, 0);
        check("midrst stage_idx", stage_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

`ifdef SEQ_TIMEOUT_EN
        // Withheld fc_done[0]: WAIT_C occupies cycles 6..21, timeout lands IDLE in cycle 22.
        c_dly[0] = NEVER;
        db = done_cnt;
        start_run();
        repeat (20) @(negedge clk);
        check("to busy_waiting", busy, 1);
        check("to error_before", error, 0);
        @(negedge clk);
        check("to error_set", error, 1);
        check("to busy", busy, 0);
        repeat (5) @(negedge clk);
        check("to no_done", done_cnt - db, 0);
        check("to error_sticky", error, 1);
        clear_delays();
        sb = st_code.size(); cb = cap_stage.size(); db = done_cnt;
        start_run();
        check("to error_cleared", error, 0);
        wait_done(db, 100, "to_rerun");
        check("to rerun_done_cycle", done_rel, 22);
        repeat (2) @(negedge clk);
`endif

        check("final error", error, 0);
        check("one_hot_starts", multi_start, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
